// File: rtl/bg_scaled_mapper.sv
// Background mapper: scales DrawX/DrawY onto an IMG_W x IMG_H indexed image with DDA counters,
// adds bank select and wrapped horizontal scroll, and colours ROM indices through per-bank palettes.
module bg_scaled_mapper #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned IMG_W    = 105,
    parameter int unsigned IMG_H    = 117,
    parameter int unsigned NUM_BG   = 4,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned ADDR_W   = 16,
    localparam int unsigned BG_W    = (NUM_BG > 1) ? $clog2(NUM_BG) : 1,
    localparam int unsigned SX_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [BG_W-1:0]   bg_sel,
    input  logic [SX_W-1:0]   scroll_x,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic              pal_we,
    input  logic [BG_W-1:0]   pal_bank,
    input  logic [IDX_W-1:0]  pal_idx,
    input  logic [11:0]       pal_data,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam int unsigned U_W   = SX_W;
    localparam int unsigned V_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned UE_W  = U_W + 1;
    localparam int unsigned AX_W  = $clog2(2 * SCREEN_W);
    localparam int unsigned AY_W  = $clog2(2 * SCREEN_H);
    localparam int unsigned PAL_N = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] BANK_SZ = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_SZ  = ADDR_W'(IMG_W);

    logic [AX_W-1:0]   accx, accx_nxt_c, accx_step_c;
    logic [AY_W-1:0]   accy, accy_nxt_c, accy_step_c;
    logic [U_W-1:0]    u, u_nxt_c;
    logic [V_W-1:0]    v, v_nxt_c;
    logic [BG_W-1:0]   bg_lat, bg_s2, bg_s3;
    logic [SX_W-1:0]   scroll_lat;
    logic              blank_d1, blank_d2, blank_d3;
    logic [UE_W-1:0]   ue_sum_c, ue_c;
    logic [ADDR_W-1:0] addr_c;
    logic [11:0]       pal_rd_c;
    logic              frame_start_c;
    logic [11:0]       pal [NUM_BG][PAL_N];

    assign frame_start_c = (DrawX == 10'd0) && (DrawY == 10'd0);

    // DDA next state: u steps every pixel, v steps once per line at DrawX==0; both saturate
    always_comb begin
        accx_step_c = accx + AX_W'(IMG_W);
        accy_step_c = accy + AY_W'(IMG_H);
        accx_nxt_c  = accx;
        u_nxt_c     = u;
        accy_nxt_c  = accy;
        v_nxt_c     = v;
        if (DrawX == 10'd0) begin
            accx_nxt_c = '0;
            u_nxt_c    = '0;
        end else if (u != U_W'(IMG_W - 1)) begin
            if (accx_step_c >= AX_W'(SCREEN_W)) begin
                accx_nxt_c = accx_step_c - AX_W'(SCREEN_W);
                u_nxt_c    = u + U_W'(1);
            end else begin
                accx_nxt_c = accx_step_c;
            end
        end
        if (DrawX == 10'd0) begin
            if (DrawY == 10'd0) begin
                accy_nxt_c = '0;
                v_nxt_c    = '0;
            end else if (v != V_W'(IMG_H - 1)) begin
                if (accy_step_c >= AY_W'(SCREEN_H)) begin
                    accy_nxt_c = accy_step_c - AY_W'(SCREEN_H);
                    v_nxt_c    = v + V_W'(1);
                end else begin
                    accy_nxt_c = accy_step_c;
                end
            end
        end
    end

    // Scroll wraps once; u and scroll are both below IMG_W so one subtraction suffices
    always_comb begin
        ue_sum_c = UE_W'(u) + UE_W'(scroll_lat);
        ue_c     = (ue_sum_c >= UE_W'(IMG_W)) ? ue_sum_c - UE_W'(IMG_W) : ue_sum_c;
        addr_c   = ADDR_W'(bg_lat) * BANK_SZ + ADDR_W'(v) * ROW_SZ + ADDR_W'(ue_c);
    end

    assign pal_rd_c = pal[bg_s3][rom_q];

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            accx       <= '0;
            accy       <= '0;
            u          <= '0;
            v          <= '0;
            bg_lat     <= '0;
            scroll_lat <= '0;
            bg_s2      <= '0;
            bg_s3      <= '0;
            blank_d1   <= 1'b0;
            blank_d2   <= 1'b0;
            blank_d3   <= 1'b0;
            rom_addr   <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            accx     <= accx_nxt_c;
            accy     <= accy_nxt_c;
            u        <= u_nxt_c;
            v        <= v_nxt_c;
            if (frame_start_c) begin
                bg_lat     <= bg_sel;
                scroll_lat <= scroll_x;
            end
            bg_s2    <= bg_lat;
            bg_s3    <= bg_s2;
            blank_d1 <= blank;
            blank_d2 <= blank_d1;
            blank_d3 <= blank_d2;
            rom_addr <= addr_c;
            {red, green, blue} <= blank_d3 ? pal_rd_c : 12'h000;
        end
    end

    // Palette write lands after this edge's read, so a same-cycle read sees the old entry
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int b = 0; b < int'(NUM_BG); b++) begin
                for (int i = 0; i < int'(PAL_N); i++) begin
                    pal[b][i] <= '0;
                end
            end
        end else if (pal_we) begin
            pal[pal_bank][pal_idx] <= pal_data;
        end
    end

endmodule

// File: tb/tb_bg_scaled_mapper.sv
// Bench for bg_scaled_mapper: table of spec addresses plus a scoreboard over every driven pixel.
module tb_bg_scaled_mapper;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IMG_W    = 105;
    localparam int IMG_H    = 117;
    localparam int BANK     = IMG_W * IMG_H;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [1:0]  bg_sel;
    logic [6:0]  scroll_x;
    logic [15:0] rom_addr;
    logic [3:0]  rom_q;
    logic        pal_we;
    logic [1:0]  pal_bank;
    logic [3:0]  pal_idx;
    logic [11:0] pal_data;
    logic [3:0]  red, green, blue;

    bg_scaled_mapper dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .bg_sel(bg_sel), .scroll_x(scroll_x), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_we(pal_we), .pal_bank(pal_bank), .pal_idx(pal_idx), .pal_data(pal_data),
        .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_f(input logic [15:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    // External synchronous ROM with one clock of latency
    always @(posedge vga_clk) rom_q <= rom_f(rom_addr);

    typedef struct { int x; int y; int bg; int sc; int exp; } vec_t;
    typedef struct { int due; int x; int y; logic [15:0] addr; } aexp_t;
    typedef struct { int due; int x; int y; bit blk; int bg; int idx; } rexp_t;

    vec_t        vecs [12];
    aexp_t       aq [$];
    rexp_t       rq [$];
    logic [11:0] pal_m [4][16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat_bg   = 0;
    int          lat_sc   = 0;
    bit          mdl_ok   = 0;
    bit          pw       = 0;
    int          pw_b, pw_i;
    logic [11:0] pw_d;

    task automatic check(input string name, input int x, input int y,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s pixel (%0d,%0d) cycle %0d: got %h expected %h", name, x, y, cyc, got, exp);
        end
    endtask

    function automatic bit vis(input int x, input int y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

    function automatic int exp_addr(input int x, input int y);
        int u, v, ue;
        u = (x * IMG_W) / SCREEN_W;
        if (u > IMG_W - 1) u = IMG_W - 1;
        v = (y * IMG_H) / SCREEN_H;
        if (v > IMG_H - 1) v = IMG_H - 1;
        ue = u + lat_sc;
        if (ue >= IMG_W) ue = ue - IMG_W;
        return lat_bg * BANK + v * IMG_W + ue;
    endfunction

    task automatic compare_due();
        aexp_t ae;
        rexp_t re;
        logic [11:0] er;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ae = aq.pop_front();
            check("rom_addr", ae.x, ae.y, 32'(rom_addr), 32'(ae.addr));
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            re = rq.pop_front();
            er = re.blk ? pal_m[re.bg][re.idx] : 12'h000;
            check("rgb", re.x, re.y, 32'({red, green, blue}), 32'(er));
        end
    endtask

    // One pixel clock: compare what is due, commit the palette write sampled last edge, drive next pixel
    task automatic step(input int x, input int y, input bit blk, input bit we,
                        input int wb, input int wi, input logic [11:0] wd, input int tgt);
        aexp_t ae;
        rexp_t re;
        int a;
        @(negedge vga_clk);
        compare_due();
        if (pw) pal_m[pw_b][pw_i] = pw_d;
        pw = we; pw_b = wb; pw_i = wi; pw_d = wd;
        DrawX = 10'(x); DrawY = 10'(y); blank = blk;
        pal_we = we; pal_bank = 2'(wb); pal_idx = 4'(wi); pal_data = wd;
        if (x == 0 && y == 0) begin
            lat_bg = int'(bg_sel); lat_sc = int'(scroll_x); mdl_ok = 1;
        end
        if (mdl_ok) begin
            a = (tgt >= 0) ? tgt : exp_addr(x, y);
            ae.due = cyc + 2; ae.x = x; ae.y = y; ae.addr = 16'(a);
            aq.push_back(ae);
            re.due = cyc + 4; re.x = x; re.y = y; re.blk = blk; re.bg = lat_bg; re.idx = int'(rom_f(16'(a)));
            rq.push_back(re);
        end
        @(posedge vga_clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        compare_due();
        if (pw) pal_m[pw_b][pw_i] = pw_d;
        pw = 0;
        aq.delete();
        rq.delete();
        mdl_ok = 0;
        reset = 1'b1;
        pal_we = 1'b0;
        @(posedge vga_clk);
        cyc++;
        @(negedge vga_clk);
        check("reset_rom_addr", int'(DrawX), int'(DrawY), 32'(rom_addr), 32'h0);
        check("reset_rgb", int'(DrawX), int'(DrawY), 32'({red, green, blue}), 32'h0);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                pal_m[b][i] = 12'h000;
        reset = 1'b0;
    endtask

    // Compressed frame: lines above the target visit only DrawX=0, target line sweeps from 0
    task automatic run_frame(input int xe, input int ye, input int tgt);
        for (int y = 0; y < ye; y++) step(0, y, vis(0, y), 0, 0, 0, 12'h000, -1);
        for (int x = 0; x <= xe + 4; x++)
            step(x, ye, vis(x, ye), 0, 0, 0, 12'h000, (x == xe) ? tgt : -1);
    endtask

    task automatic idle(input int n);
        mdl_ok = 0;
        for (int k = 0; k < n; k++) step(700, 500, 0, 0, 0, 0, 12'h000, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{639, 479, 0,   0, 12284};
        vecs[1]  = '{  0,   0, 0,   0,     0};
        vecs[2]  = '{  6,   0, 0,   0,     0};
        vecs[3]  = '{  7,   0, 0,   0,     1};
        vecs[4]  = '{639, 479, 0,  10, 12189};
        vecs[5]  = '{  0,   0, 0,  10,    10};
        vecs[6]  = '{  0,   0, 2,   0, 24570};
        vecs[7]  = '{700,   0, 2,   0, 24674};
        vecs[8]  = '{  0,   0, 3, 104, 36959};
        vecs[9]  = '{639, 479, 1,  50, 24514};
        vecs[10] = '{639, 524, 3,   0, 49139};
        vecs[11] = '{100, 240, 0,   0,  6106};

        reset = 1'b0; DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
        bg_sel = 2'd0; scroll_x = 7'd0; pal_we = 1'b0; pal_bank = 2'd0; pal_idx = 4'd0; pal_data = 12'h000;
        do_reset();
        do_reset();

        // Nonzero palette in every bank so colour lookups are observable
        mdl_ok = 0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                step(700, 500, 0, 1, b, i, {4'(b + 1), 4'(i), 4'(15 - i)}, -1);
        idle(2);

        for (int k = 0; k < 12; k++) begin
            bg_sel = 2'(vecs[k].bg);
            scroll_x = 7'(vecs[k].sc);
            run_frame(vecs[k].x, vecs[k].y, vecs[k].exp);
        end

        // Mid-frame scroll change must not move the image until the next frame
        bg_sel = 2'd0; scroll_x = 7'd10;
        for (int x = 0; x <= 30; x++) begin
            if (x == 5) scroll_x = 7'd40;
            step(x, 0, 1, 0, 0, 0, 12'h000, -1);
        end
        run_frame(3, 0, 40);

        // Single-pixel blank pulse
        bg_sel = 2'd1; scroll_x = 7'd0;
        for (int x = 0; x <= 20; x++) step(x, 0, (x == 12), 0, 0, 0, 12'h000, -1);

        // Reset during active video, then a frame whose palette reads must all be zero
        bg_sel = 2'd0; scroll_x = 7'd0;
        for (int x = 0; x <= 50; x++) step(x, 0, 1, 0, 0, 0, 12'h000, -1);
        do_reset();
        run_frame(20, 2, -1);

        // Palette write then a same-cycle write/read collision on bank0 idx3
        idle(1);
        step(700, 500, 0, 1, 0, 3, 12'hF80, -1);
        idle(2);
        bg_sel = 2'd0; scroll_x = 7'd0;
        for (int x = 0; x <= 30; x++) step(x, 0, 1, (x == 22), 0, 3, 12'h0A5, (x == 19) ? 3 : -1);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
